// File: rtl/tick_gen.sv
// tick_gen: programmable tick generator feeding a downstream counter's enable.
// Period is div+1 clocks; periodic mode runs until stopped, one-shot mode
// issues exactly `count` ticks and then pulses `done`.
// Optional macro TICK_GEN_RESTART_EN: a start request while running
// re-captures the configuration and restarts the prescaler.
//
// state | meaning
// IDLE  | waiting for an accepted start; busy low
// RUN   | prescaler counting, ticks issued every div+1 cycles; busy high
module tick_gen #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          oneshot,
   input  logic [DW-1:0] div,
   input  logic [DW-1:0] count,
   output logic          tick,
   output logic          busy,
   output logic          done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state, state_nx;
   logic [DW-1:0] pcnt, pcnt_nx;
   logic [DW-1:0] rem, rem_nx;
   logic [DW-1:0] div_q, div_nx;
   logic          oneshot_q, oneshot_nx;
   logic          tick_nx, done_nx;
   logic          load;

   // State, counters, captured configuration and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pcnt      <= '0;
         rem       <= '0;
         div_q     <= '0;
         oneshot_q <= 1'b0;
         tick      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         pcnt      <= pcnt_nx;
         rem       <= rem_nx;
         div_q     <= div_nx;
         oneshot_q <= oneshot_nx;
         tick      <= tick_nx;
         done      <= done_nx;
      end
   end

   // Next-state, prescaler and one-shot bookkeeping.
   always_comb begin
      state_nx   = state;
      pcnt_nx    = pcnt;
      rem_nx     = rem;
      div_nx     = div_q;
      oneshot_nx = oneshot_q;
      tick_nx    = 1'b0;
      done_nx    = 1'b0;
      load       = 1'b0;

      case (state)
         IDLE: begin
            if (start && !stop) load = 1'b1;
         end
         RUN: begin
            // stop beats a due tick and any restart request
            if (stop) begin
               state_nx = IDLE;
               pcnt_nx  = '0;
            end
`ifdef TICK_GEN_RESTART_EN
            else if (start) begin
               load = 1'b1;
            end
`endif
            else if (pcnt == div_q) begin
               pcnt_nx = '0;
               tick_nx = 1'b1;
               if (oneshot_q) begin
                  rem_nx = rem - DW'(1);
                  if (rem == DW'(1)) begin
                     state_nx = IDLE;
                     done_nx  = 1'b1;
                  end
               end
            end else begin
               pcnt_nx = pcnt + DW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      // A zero-length one-shot completes immediately without a tick.
      if (load) begin
         div_nx     = div;
         oneshot_nx = oneshot;
         pcnt_nx    = '0;
         rem_nx     = count;
         if (oneshot && (count == '0)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
         end else begin
            state_nx = RUN;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: an arithmetic reference model (ticks at start_edge +
// n*(div+1)) checked every cycle, plus directed literal expectations.
module tb_tick_gen;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, oneshot = 1'b0;
   logic [DW-1:0] div = '0, count = '0;
   logic          tick, busy, done;

   logic          s_start = 1'b0, s_stop = 1'b0, s_os = 1'b0;
   logic [3:0]    s_div = '0, s_count = '0;
   logic          s_tick, s_busy, s_done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   tick_gen #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .oneshot(oneshot),
      .div(div), .count(count), .tick(tick), .busy(busy), .done(done)
   );

   tick_gen #(.DW(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .oneshot(s_os),
      .div(s_div), .count(s_count), .tick(s_tick), .busy(s_busy), .done(s_done)
   );

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0b required %0b", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit     m_run = 1'b0, m_os = 1'b0;
   longint m_cyc = 0, m_k = 0, m_period = 1;
   int     m_cnt = 0, m_issued = 0;
   bit     exp_tick = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

   task automatic m_accept();
      if (oneshot && count == '0) begin
         m_run    = 1'b0;
         exp_done = 1'b1;
      end else begin
         m_run    = 1'b1;
         m_k      = m_cyc;
         m_period = longint'(div) + 1;
         m_os     = oneshot;
         m_cnt    = int'(count);
         m_issued = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 1'b0; exp_tick = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; m_cyc = 0;
      end else begin
         m_cyc++;
         exp_tick = 1'b0;
         exp_done = 1'b0;
         if (m_run) begin
            if (stop) m_run = 1'b0;
`ifdef TICK_GEN_RESTART_EN
            else if (start) m_accept();
`endif
            else if ((m_cyc - m_k) % m_period == 0) begin
               exp_tick = 1'b1;
               m_issued++;
               if (m_os && m_issued == m_cnt) begin
                  m_run    = 1'b0;
                  exp_done = 1'b1;
               end
            end
         end else if (start && !stop) begin
            m_accept();
         end
         exp_busy = m_run;
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk($sformatf("model tick c%0d", m_cyc), tick, exp_tick);
         chk($sformatf("model busy c%0d", m_cyc), busy, exp_busy);
         chk($sformatf("model done c%0d", m_cyc), done, exp_done);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      int mcnt;
      logic co;

      // 1: reset release, no stimulus
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk($sformatf("t1 tick e%0d", e), tick, 1'b0);
         chk($sformatf("t1 busy e%0d", e), busy, 1'b0);
         chk($sformatf("t1 done e%0d", e), done, 1'b0);
      end

      // 2: periodic div=3, stop at edge 10; div change after start ignored
      div = 16'd3; oneshot = 1'b0; start = 1'b1;
      step();
      start = 1'b0; div = 16'd7;
      for (int e = 1; e <= 13; e++) begin
         stop = (e == 10);
         step();
         chk($sformatf("t2 tick e%0d", e), tick, (e == 4 || e == 8));
         chk($sformatf("t2 busy e%0d", e), busy, (e < 10));
         chk($sformatf("t2 done e%0d", e), done, 1'b0);
      end
      stop = 1'b0;

      // 3: one-shot div=2 count=3, then count=0
      div = 16'd2; count = 16'd3; oneshot = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         step();
         chk($sformatf("t3 tick e%0d", e), tick, (e == 3 || e == 6 || e == 9));
         chk($sformatf("t3 done e%0d", e), done, (e == 9));
         chk($sformatf("t3 busy e%0d", e), busy, (e < 9));
      end
      count = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      chk("t3 zero done", done, 1'b1);
      chk("t3 zero tick", tick, 1'b0);
      chk("t3 zero busy", busy, 1'b0);
      step();
      chk("t3 zero done drop", done, 1'b0);

      // 4: div=0 drives a max=4 modulo counter
      div = 16'd0; oneshot = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      mcnt = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         chk($sformatf("t4 tick e%0d", e), tick, 1'b1);
         co = tick && (mcnt == 4);
         if (tick) mcnt = (mcnt == 4) ? 0 : mcnt + 1;
         chk($sformatf("t4 co e%0d", e), co, (e % 5 == 0));
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4 stopped busy", busy, 1'b0);

      // 5: stop coincident with due tick; start+stop in IDLE; stop alone in IDLE
      div = 16'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         stop = (e == 4);
         step();
         chk($sformatf("t5 tick e%0d", e), tick, (e == 2));
         chk($sformatf("t5 busy e%0d", e), busy, (e < 4));
      end
      start = 1'b1; stop = 1'b1;
      step();
      chk("t5 start+stop busy", busy, 1'b0);
      start = 1'b0;
      step();
      chk("t5 stop-only busy", busy, 1'b0);
      stop = 1'b0;
      step();
      chk("t5 idle tick", tick, 1'b0);

      // 6a: async reset mid-RUN while tick is high
      div = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("t6 pre-reset tick", tick, 1'b1);
      chk("t6 pre-reset busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6 reset tick", tick, 1'b0);
      chk("t6 reset busy", busy, 1'b0);
      chk("t6 reset done", done, 1'b0);
      rst_n = 1'b1;
      step();
      chk("t6 post-reset busy", busy, 1'b0);
      chk("t6 post-reset done", done, 1'b0);

      // 6b: start in RUN at edge 7 with div=5
      div = 16'd2; start = 1'b1;
      step();
      for (int e = 1; e <= 14; e++) begin
         start = (e == 7);
         if (e == 7) div = 16'd5;
         step();
`ifdef TICK_GEN_RESTART_EN
         chk($sformatf("t6 restart tick e%0d", e), tick, (e == 3 || e == 6 || e == 13));
`else
         chk($sformatf("t6 restart tick e%0d", e), tick, (e % 3 == 0));
`endif
      end
      start = 1'b0; stop = 1'b1;
      step();
      stop = 1'b0;

      // full-range divisor on a 4-bit instance: div=15, period 16
      s_div = 4'hF; s_count = 4'd2; s_os = 1'b1; s_start = 1'b1;
      step();
      s_start = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         step();
         chk($sformatf("small tick e%0d", e), s_tick, (e == 16 || e == 32));
         chk($sformatf("small done e%0d", e), s_done, (e == 32));
         chk($sformatf("small busy e%0d", e), s_busy, (e < 32));
      end

      // random phase, checked by the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 2) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         start   = ($urandom_range(0, 7) == 0);
         stop    = ($urandom_range(0, 29) == 0);
         oneshot = 1'($urandom_range(0, 1));
         div     = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40))
                                               : 16'($urandom_range(0, 5));
         count   = 16'($urandom_range(0, 5));
         step();
      end
      start = 1'b0; stop = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
